// File: rtl/word_packer_if.sv
// Byte-in / word-out handshake bundle for word_packer.
// The slave modport is the packer's view and the master modport is the byte source and word sink.
interface word_packer_if #(
  parameter int unsigned LANES = 4
) ();
  logic [7:0]                   data_in;
  logic                         in_valid;
  logic                         in_ready;
  logic                         flush;
  logic [8*LANES-1:0]           data_out;
  logic [$clog2(LANES+1)-1:0]   out_count;
  logic [7:0]                   out_csum;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output data_in, in_valid, flush, out_ready,
    input  in_ready, data_out, out_count, out_csum, out_valid
  );

  modport slave (
    input  data_in, in_valid, flush, out_ready,
    output in_ready, data_out, out_count, out_csum, out_valid
  );
endinterface

// File: rtl/word_packer.sv
// Packs an 8-bit byte stream into LANES-byte words with a count and a mod-256 checksum.
// Words are buffered in a small FIFO that feeds a valid/ready sink; a flush emits a partial word.
module word_packer #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  word_packer_if.slave bus
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = 8 * LANES;

  logic [7:0]    acc_q [LANES];
  logic [7:0]    acc_d [LANES];
  logic [LW-1:0] cnt_q, cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic          pend_q, pend_d;

  logic [WW-1:0] mem_data_q [FIFO_DEPTH];
  logic [CW-1:0] mem_cnt_q  [FIFO_DEPTH];
  logic [7:0]    mem_csum_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q;

  logic          full, accept, pop, flush_req, word_done, push;
  logic [7:0]    acc_new [LANES];
  logic [CW-1:0] fill, push_cnt;
  logic [7:0]    sum_new;
  logic [WW-1:0] push_word;

  assign full      = (occ_q == OW'(FIFO_DEPTH));
  assign accept    = bus.in_valid && !full;
  assign pop       = (occ_q != '0) && bus.out_ready;
  assign flush_req = pend_q || bus.flush;

  always_comb begin
    acc_new = acc_q;
    if (accept) acc_new[cnt_q] = bus.data_in;
    fill      = CW'(cnt_q) + CW'(accept);
    sum_new   = csum_q + (accept ? bus.data_in : 8'h00);
    word_done = accept && (cnt_q == LW'(LANES - 1));

    push_word = '0;
    for (int unsigned i = 0; i < LANES; i++) push_word[8*i +: 8] = acc_new[i];

    push     = 1'b0;
    push_cnt = '0;
    acc_d    = acc_new;
    cnt_d    = fill[LW-1:0];
    csum_d   = sum_new;
    pend_d   = flush_req;

    // A completing byte absorbs any pending flush, so flush never adds an empty word after it.
    if (word_done || (flush_req && !full)) begin
      push     = word_done || (fill != '0);
      push_cnt = word_done ? CW'(LANES) : fill;
      cnt_d    = '0;
      csum_d   = '0;
      pend_d   = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) acc_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LANES; i++) acc_q[i] <= '0;
      cnt_q  <= '0;
      csum_q <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      csum_q <= csum_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_cnt_q[i]  <= '0;
        mem_csum_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= push_word;
        mem_cnt_q[wr_ptr_q]  <= push_cnt;
        mem_csum_q[wr_ptr_q] <= sum_new;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      occ_q <= occ_q + OW'(push) - OW'(pop);
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = (occ_q != '0);
  assign bus.data_out  = mem_data_q[rd_ptr_q];
  assign bus.out_count = mem_cnt_q[rd_ptr_q];
  assign bus.out_csum  = mem_csum_q[rd_ptr_q];
endmodule

// File: doc/word_packer.md
# word_packer

Downstream consumer of the 8-bit processing stage's byte stream: gathers consecutive bytes into `LANES`-byte words and buffers them in a small FIFO. Drives them out on a valid/ready interface with a per-word byte count and modulo-256 checksum. Decouples the byte-per-cycle datapath from a wider sink that may stall. A flush request emits a partially filled word.

## Interface
Parameters:
- `LANES`, 4, bytes per output word; ≥2.
- `FIFO_DEPTH`, 2, output word buffer entries; power of 2, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `data_in`  in  8  byte from the upstream stage.
- `in_valid`  in  1  `data_in` is valid this cycle.
- `in_ready`  out  1  block accepts a byte this cycle; a transfer happens when `in_valid && in_ready`.
- `flush`  in  1  single-cycle pulse; requests output of the current partial word.
- `data_out`  out  8*LANES  packed word; the first-accepted byte is in bits [7:0].
- `out_count`  out  $clog2(LANES+1)  number of valid bytes in `data_out`, 1..LANES.
- `out_csum`  out  8  modulo-256 sum of the valid bytes of the word.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  sink accepts the head; a transfer happens when `out_valid && out_ready`.

## Operation
- **Accumulator.** Registers `acc[LANES]`, lane index `cnt` (0..LANES-1) and running sum `csum`.
- **Byte accept.** An accepted byte is written to `acc[cnt]`. `csum` becomes `csum + data_in` mod 256. `cnt` increments.
- **Word push.** When the accepted byte lands in lane `LANES-1`, the block builds the word in the same cycle:
  - data = accumulator contents including the new byte;
  - `out_count` = LANES;
  - `out_csum` = `csum + data_in`.
  
  It pushes this word to the FIFO and clears `cnt`, `csum` and `acc` to 0.
- **Input backpressure.** `in_ready` = FIFO not full. It is conservative: it is low whenever the FIFO is full, even if the head pops in that cycle.
- **Flush latching.** A `flush` pulse sets `flush_pend`.
- **Flush action.** When `flush_pend` is set, the FIFO is not full and `cnt` > 0, the block pushes the partial word and clears the accumulator and `flush_pend`:
  - unused upper lanes are 0;
  - `out_count` = `cnt` (after including any byte accepted that cycle).
- **Flush with empty accumulator.** If `flush_pend` is set and `cnt` = 0 with no byte accepted that cycle, the block clears `flush_pend` and pushes nothing.
- **Flush and byte in the same cycle.** The byte is included first. If that byte completes the word, only one push occurs (a full word) and `flush_pend` clears.
- **Flush while the FIFO is full.** `flush_pend` holds until space frees. No bytes are accepted meanwhile, because `in_ready` is 0.
- **FIFO.** Circular buffer with wrapping read/write pointers and an occupancy counter. Push and pop in the same cycle are legal and leave occupancy unchanged.
- **Output stability.** `data_out`, `out_count` and `out_csum` come from the head entry. They are stable while `out_valid && !out_ready`.

## Timing
- **Reset values** (while `rst_n` low):
  - `out_valid`=0, `data_out`=0, `out_count`=0, `out_csum`=0;
  - `in_ready`=1 (FIFO empty), but no transfers are taken while `rst_n` is low;
  - `cnt`, `csum`, `acc`, `flush_pend`, FIFO pointers and occupancy = 0.
- **Reset mid-word.** Partial accumulator contents and buffered words are discarded, with no output.
- **Latency.** The completing byte accepted at edge N gives `out_valid`=1 after edge N. Same for a flush push.
- **Input throughput.** One byte per cycle sustained while `out_ready` is held high.
- **Output throughput.** One word per cycle from the FIFO.
- **FIFO full.** Occupancy = `FIFO_DEPTH` drives `in_ready`=0 in that cycle. It returns to 1 the cycle after the first pop.
- **Pointer wrap.** Wrap-around from `FIFO_DEPTH-1` to 0 must be seamless; there is no bubble.

## Test plan
- **Full-word pack.** LANES=4; bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles; `out_ready`=1 → one word `data_out`=0x44332211, `out_count`=4, `out_csum`=0xAA, `out_valid` high one cycle after the 0x44 accept.
- **Partial flush.** Bytes 0x01,0x02, then `flush` → `data_out`=0x00000201, `out_count`=2, `out_csum`=0x03. A following `flush` with an empty accumulator produces no word.
- **Flush with completing byte.** `flush` coincides with the 4th byte → exactly one word, `out_count`=4, and no extra empty word.
- **Backpressure.**
  - Stimulus: `out_ready`=0; stream 0x00..0x0B.
  - Required: after 8 bytes the FIFO holds 2 words and `in_ready`=0; bytes 0x08.. are not accepted.
  - Then `out_ready`=1: words 0x03020100 and 0x07060504 emerge in order; `in_ready` rises the cycle after the first pop.
- **Checksum wrap.** Bytes 0xFF,0xFF,0xFF,0x04 → `out_csum`=0x01.
- **Reset mid-operation.** Assert `rst_n`=0 after 2 bytes are accepted, with one word queued.
  - Required: `out_valid`=0 immediately (asynchronous).
  - After release, bytes 0xA0..0xA3 yield 0xA3A2A1A0 with `out_count`=4; no stale data appears.
